full_adder: RTL and testbench
=============================

FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter WIDTH, default 1, operand width in bits; legal range 1 to 64.
REQ-002 Port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 Port rst, input, 1, reset, synchronous and active-high, sampled on rising clk.
REQ-004 Port A, input, WIDTH, addend A (unsigned).
REQ-005 Port B, input, WIDTH, addend B (unsigned).
REQ-006 Port CIN, input, 1, carry-in to bit 0.
REQ-007 Port SUM, output, WIDTH, combinational sum bits.
REQ-008 Port CARRY, output, 1, combinational carry-out of the MSB.
REQ-009 Port SUM_Q, output, WIDTH, SUM registered on clk.
REQ-010 Port CARRY_Q, output, 1, CARRY registered on clk.

Function
REQ-011 {CARRY, SUM} SHALL equal A + B + CIN, computed at WIDTH+1 bits with no truncation.
REQ-012 For WIDTH=1: SUM SHALL equal A xor B xor CIN, and CARRY SHALL equal the majority (A&B | A&CIN | B&CIN).
REQ-013 SUM and CARRY SHALL be purely combinational, with zero clock latency, and SHALL be independent of clk and rst.
REQ-014 The adder SHALL be a ripple chain: bit i carry-in is bit i-1 carry-out, and bit 0 carry-in is CIN.
REQ-015 SUM_Q and CARRY_Q SHALL capture SUM and CARRY on each rising clk when rst is low, giving 1-cycle latency.
REQ-016 Overflow SHALL wrap: {CARRY, SUM} SHALL be exact, SUM alone SHALL be modulo 2^WIDTH, and no saturation is applied.
REQ-017 An X or Z value on any input bit SHALL NOT be masked; propagation to outputs is permitted.

Reset
REQ-018 While rst is high at a rising clk edge, SUM_Q SHALL load 0 and CARRY_Q SHALL load 0.
REQ-019 rst SHALL NOT affect SUM or CARRY, which continue to track their inputs during reset.
REQ-020 On the first rising edge after rst falls, the registered outputs SHALL capture the current combinational result.
REQ-021 rst asserted mid-operation SHALL take priority over capture on that same edge.

Structure
REQ-022 A leaf sub-module full_adder_bit (a, b, cin -> s, cout; combinational) SHALL be instantiated WIDTH times via generate.
REQ-023 No shared package is required; WIDTH is the only configuration constant.
REQ-024 The output register stage SHALL reside in full_adder, not in full_adder_bit.

Verification
REQ-025 WIDTH=1, all 8 combinations of A/B/CIN held for 10 ns each -> SUM/CARRY = 000->0/0, 001->1/0, 010->1/0, 100->1/0, 110->0/1, 101->0/1, 011->0/1, 111->1/1.
REQ-026 WIDTH=1, apply A=1 B=1 CIN=1 then one rising clk edge with rst=0 -> SUM_Q=1, CARRY_Q=1.
REQ-027 Assert rst for one edge while A=1 B=1 CIN=1 -> SUM_Q=0 and CARRY_Q=0, while SUM=1 and CARRY=1 still hold.
REQ-028 WIDTH=8, A=8'hFF, B=8'h00, CIN=1 -> SUM=8'h00, CARRY=1; after the next clk edge, SUM_Q=8'h00 and CARRY_Q=1.
REQ-029 WIDTH=8, 1000 random A/B/CIN vectors -> every result matches the A+B+CIN reference model, combinationally and one cycle later on the registered outputs.
REQ-030 Change inputs between clock edges -> SUM_Q/CARRY_Q stay stable until the next rising edge, while SUM/CARRY follow the inputs immediately.

Source files
------------

// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder ripple-carry adder slice.
package full_adder_pkg;

  localparam int unsigned MIN_WIDTH = 1;
  localparam int unsigned MAX_WIDTH = 64;

endpackage : full_adder_pkg

// File: rtl/full_adder_bit.sv
// One-bit combinational full adder cell; the ripple chain links these cells together.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_bit

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with a combinational result and a registered copy.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY,
  output logic [WIDTH-1:0] SUM_Q,
  output logic             CARRY_Q
);

  // Reject widths outside the supported range at elaboration time.
  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("full_adder: WIDTH %0d outside supported range", WIDTH);
  end

  // carry_chain[i] is the carry into bit i; carry_chain[WIDTH] leaves the MSB.
  logic [WIDTH:0] carry_chain;

  assign carry_chain[0] = CIN;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_bit (
      .a   (A[i]),
      .b   (B[i]),
      .cin (carry_chain[i]),
      .s   (SUM[i]),
      .cout(carry_chain[i+1])
    );
  end

  assign CARRY = carry_chain[WIDTH];

  // Output register; reset wins over capture on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      SUM_Q   <= '0;
      CARRY_Q <= 1'b0;
    end else begin
      SUM_Q   <= SUM;
      CARRY_Q <= CARRY;
    end
  end

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1 and WIDTH=8 against an arithmetic model.
module tb_full_adder;

  localparam int unsigned W8 = 8;

  logic          clk;
  logic          rst;
  logic          a1, b1, cin1;
  logic          sum1, carry1, sum1_q, carry1_q;
  logic [W8-1:0] a8, b8;
  logic          cin8;
  logic [W8-1:0] sum8, sum8_q;
  logic          carry8, carry8_q;

  int unsigned errors;
  int unsigned checks;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .A      (a1),
    .B      (b1),
    .CIN    (cin1),
    .SUM    (sum1),
    .CARRY  (carry1),
    .SUM_Q  (sum1_q),
    .CARRY_Q(carry1_q)
  );

  full_adder #(.WIDTH(W8)) u_dut8 (
    .clk    (clk),
    .rst    (rst),
    .A      (a8),
    .B      (b8),
    .CIN    (cin8),
    .SUM    (sum8),
    .CARRY  (carry8),
    .SUM_Q  (sum8_q),
    .CARRY_Q(carry8_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact WIDTH+1 bit arithmetic sum.
  function automatic logic [W8:0] ref8(input logic [W8-1:0] a, input logic [W8-1:0] b, input logic c);
    return (W8+1)'(a) + (W8+1)'(b) + (W8+1)'(c);
  endfunction

  function automatic logic [1:0] ref1(input logic a, input logic b, input logic c);
    int t;
    t = int'(a) + int'(b) + int'(c);
    return 2'(t);
  endfunction

  logic [W8:0] exp8;
  logic [1:0]  exp1;

  initial begin
    errors = 0;
    checks = 0;
    rst  = 1'b1;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    a8 = '0;   b8 = '0;   cin8 = 1'b0;

    // Reset state of the registered outputs.
    @(posedge clk); @(posedge clk); #1;
    check("reset_sum1_q",   64'(sum1_q),   64'd0);
    check("reset_carry1_q", 64'(carry1_q), 64'd0);
    check("reset_sum8_q",   64'(sum8_q),   64'd0);
    check("reset_carry8_q", 64'(carry8_q), 64'd0);

    // WIDTH=1 exhaustive, held 10 ns each; works with rst still high.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {a1, b1, cin1} = v;
      #10;
      exp1 = ref1(v[2], v[1], v[0]);
      check("w1_sum",   64'(sum1),   64'(exp1[0]));
      check("w1_carry", 64'(carry1), 64'(exp1[1]));
    end

    // Release reset; first edge captures the current combinational result.
    @(negedge clk);
    rst = 1'b0;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1;
    #1;
    check("ovf_sum8",   64'(sum8),   64'h00);
    check("ovf_carry8", 64'(carry8), 64'd1);
    @(posedge clk); #1;
    check("cap_sum1_q",   64'(sum1_q),   64'd1);
    check("cap_carry1_q", 64'(carry1_q), 64'd1);
    check("ovf_sum8_q",   64'(sum8_q),   64'h00);
    check("ovf_carry8_q", 64'(carry8_q), 64'd1);

    // Reset mid-operation takes priority; combinational path unaffected.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_sum1_q",   64'(sum1_q),   64'd0);
    check("rst_carry1_q", 64'(carry1_q), 64'd0);
    check("rst_sum1",     64'(sum1),     64'd1);
    check("rst_carry1",   64'(carry1),   64'd1);
    check("rst_carry8_q", 64'(carry8_q), 64'd0);
    check("rst_carry8",   64'(carry8),   64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Random vectors: combinational now, registered one edge later.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom);
      a1   = 1'($urandom);
      b1   = 1'($urandom);
      cin1 = 1'($urandom);
      exp8 = ref8(a8, b8, cin8);
      exp1 = ref1(a1, b1, cin1);
      #1;
      check("rnd_sum8",   64'(sum8),   64'(exp8[W8-1:0]));
      check("rnd_carry8", 64'(carry8), 64'(exp8[W8]));
      check("rnd_sum1",   64'(sum1),   64'(exp1[0]));
      check("rnd_carry1", 64'(carry1), 64'(exp1[1]));
      @(posedge clk); #1;
      check("rnd_sum8_q",   64'(sum8_q),   64'(exp8[W8-1:0]));
      check("rnd_carry8_q", 64'(carry8_q), 64'(exp8[W8]));
      check("rnd_sum1_q",   64'(sum1_q),   64'(exp1[0]));
      check("rnd_carry1_q", 64'(carry1_q), 64'(exp1[1]));
    end

    // Mid-cycle input change: registered outputs hold, combinational follow.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    @(posedge clk); #1;
    check("hold_pre_sum8_q", 64'(sum8_q), 64'h46);
    #2;
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1;
    #1;
    check("hold_sum8",     64'(sum8),     64'h01);
    check("hold_carry8",   64'(carry8),   64'd1);
    check("hold_sum8_q",   64'(sum8_q),   64'h46);
    check("hold_carry8_q", 64'(carry8_q), 64'd0);
    @(posedge clk); #1;
    check("next_sum8_q",   64'(sum8_q),   64'h01);
    check("next_carry8_q", 64'(carry8_q), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_full_adder
